parity_stream: RTL
==================

# parity_stream

Parametrised, clocked parity generator/checker for the ALU datapath; the sequential successor to the combinational 4-input XOR. Accepts a stream of WIDTH-bit beats under a valid/ready handshake and XOR-reduces every accepted beat into a running frame parity. On the frame's last beat it presents the even/odd parity bit and a check error flag, held until the consumer accepts it.

## Interface
- WIDTH, 4, data beat width in bits, ≥1
- CNT_W, 8, beat counter width (used only with PARITY_STREAM_CNT_EN)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset: asynchronous, active-low; one clock domain only
- flush  input  1  synchronous abort of any open frame or held result
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  WIDTH  beat payload
- in_last  input  1  final beat of frame
- in_odd  input  1  1 = odd parity, 0 = even; sampled on first beat of frame
- in_chk  input  1  received parity bit; sampled on last beat
- out_valid  output  1  result held
- out_ready  input  1  result consumed when out_valid && out_ready
- out_parity  output  1  generated parity bit
- out_err  output  1  check mismatch
- out_beats  output  CNT_W  beats in frame (only with PARITY_STREAM_CNT_EN)

## Operation
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. out_valid = 1 only in HOLD.
- IDLE, beat accepted: acc <= ^in_data; odd_q <= in_odd; go to HOLD if in_last, else ACCUM.
- ACCUM, beat accepted: acc <= acc ^ (^in_data); on in_last go to HOLD. in_odd is ignored after the first beat.
- out_parity = acc ^ odd_q, so that data plus parity has the requested even/odd weight.
- out_err = (acc ^ in_chk_q) != odd_q, where in_chk_q is latched on the last beat.
- HOLD: outputs remain stable while out_ready = 0. When out_ready = 1, return to IDLE next cycle.
- flush = 1: go to IDLE, clear acc, odd_q, in_chk_q and the counter, and drop any held result. flush takes priority over a simultaneous beat or out_ready; a beat offered in the flush cycle is not accepted (in_ready still reads 1 but the beat is discarded, so the upstream must not assert flush and in_valid together).
- No beats are lost in ACCUM; each beat accepted in a cycle is reduced in that same cycle.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_parity=0, out_err=0, out_beats=0, all internal registers 0.
- Reset asserted mid-frame or in HOLD: the frame is discarded and outputs take reset values immediately, without waiting for a clock edge.
- Latency: out_valid rises on the cycle after the last beat is accepted.
- Throughput: one beat per cycle in a frame. There is one bubble cycle between frames, because in_ready = 0 in HOLD and in_ready = 1 only from the cycle after the result is consumed.
- out_* are registered and glitch-free. in_ready is decoded from the registered state only.

## Configuration
- PARITY_STREAM_CNT_EN defined: adds the out_beats port and a CNT_W-bit counter.
  - The counter loads 1 on the first beat and increments on each later beat.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - The value is held in HOLD and cleared by flush or reset.
- PARITY_STREAM_CNT_EN undefined: no counter logic and no out_beats port; all other behaviour is identical.

## Structure
- The shared package parity_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - the parity mode constants PAR_EVEN = 0 and PAR_ODD = 1.
- Sub-module xor_reduce: a parametrised WIDTH-input XOR tree, purely combinational, with output y. It is instantiated once for in_data.
- All state logic lives in parity_stream.

## Test plan
- WIDTH=4, even mode, single beat 4'b0001 with in_last → next cycle out_valid=1, out_parity=1, out_err=0 (in_chk=1).
- Even mode, 3-beat frame 4'hF, 4'h1, 4'h3 → out_parity=1. Same frame in odd mode → out_parity=0.
- Even mode, check frame 4'h7: in_chk=1 → out_err=0; in_chk=0 → out_err=1.
- Hold out_ready=0 for 5 cycles after the result → out_valid, out_parity and out_err are stable, in_ready=0. Raise out_ready → IDLE, with in_ready=1 on the next cycle.
- flush after 2 beats of 4'h1, then a new single-beat frame 4'h1 → out_parity=1, unaffected by the discarded beats.
- Async rst_n low mid-ACCUM → outputs are 0 before the next edge. With PARITY_STREAM_CNT_EN, CNT_W=2 and a 5-beat frame → out_beats=3 (saturated).

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types for the parity stream datapath: frame FSM states and parity modes.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/xor_reduce.sv
// Purely combinational WIDTH-input XOR tree reducing one data beat to a single parity bit.
module xor_reduce #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic             y
);

    assign y = ^a;

endmodule

// File: rtl/parity_stream.sv
// Streaming even/odd parity generator/checker with a valid/ready handshake on both sides.
// Optional beat counter and out_beats port are enabled by defining PARITY_STREAM_CNT_EN.
module parity_stream
    import parity_pkg::*;
#(
    parameter int WIDTH = 4
`ifdef PARITY_STREAM_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_odd,
    input  logic             in_chk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err
`ifdef PARITY_STREAM_CNT_EN
    , output logic [CNT_W-1:0] out_beats
`endif
);

    state_t state;
    logic   acc;
    logic   odd_q;
    logic   chk_q;
    logic   beat_par;
    logic   accept;
    logic   acc_next;
    logic   odd_next;

    xor_reduce #(.WIDTH(WIDTH)) u_xor_reduce (
        .a (in_data),
        .y (beat_par)
    );

    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;

    // The first beat of a frame restarts the running parity and latches the mode.
    assign acc_next = (state == IDLE) ? beat_par : (acc ^ beat_par);
    assign odd_next = (state == IDLE) ? (in_odd == PAR_ODD) : odd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 1'b0;
            odd_q <= PAR_EVEN;
            chk_q <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            acc   <= 1'b0;
            odd_q <= PAR_EVEN;
            chk_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= acc_next;
                        odd_q <= odd_next;
                        if (in_last) begin
                            chk_q <= in_chk;
                            state <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded only from registers, so they stay glitch-free and frozen in HOLD.
    assign out_valid  = (state == HOLD);
    assign out_parity = acc ^ odd_q;
    assign out_err    = ((acc ^ chk_q) != odd_q);

`ifdef PARITY_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating beat count; it is left untouched in HOLD so the consumer sees the frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                cnt <= CNT_W'(1);
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_beats = cnt;
`endif

endmodule
